// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side buffer: entry width,
// status-byte bit positions and the capture FSM encoding.
package uart_pkg;

  localparam int ENTRY_W = 11;

  localparam int ST_RDY  = 0;
  localparam int ST_PERR = 2;
  localparam int ST_FERR = 3;
  localparam int ST_OVF  = 4;
  localparam int ST_DROP = 5;
  localparam int ST_FULL = 6;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } cap_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a show-ahead head output. Storage is not
// reset; only the pointers and the occupancy count are.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_eff, rd_eff;

  assign empty  = (count_q == '0);
  assign full   = (count_q == (AW+1)'(DEPTH));
  // A read on a full FIFO frees the slot the simultaneous write lands in.
  assign rd_eff = rd_en && !empty;
  assign wr_eff = wr_en && (!full || rd_eff);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_eff) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_eff) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_eff, rd_eff})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_eff) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/rx_buffer.sv
// Receive buffer behind the UART engine: captures one entry per RXRDY
// assertion, pulses clr back to the engine, and exposes a show-ahead read port.
module rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rxrdy_in,
  input  logic [7:0]    data_in,
  input  logic          perr_in,
  input  logic          ferr_in,
  input  logic          ovf_in,
  output logic          clr_out,
  input  logic          rd,
  input  logic          drop_clr,
  output logic [7:0]    rd_data,
  output logic [7:0]    rd_status,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  cap_state_e           state_q;
  logic                 clr_q;
  logic                 drop_q, drop_d;
  logic                 capture, wr_ok;
  logic [ENTRY_W-1:0]   head;

  assign capture = (state_q == IDLE) && rxrdy_in;
  assign wr_ok   = capture && (!full || rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      clr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (rxrdy_in) begin
          state_q <= CLEAR;
          clr_q   <= 1'b1;
        end
        CLEAR: if (!rxrdy_in) begin
          state_q <= IDLE;
          clr_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          clr_q   <= 1'b0;
        end
      endcase
    end
  end

  // A discard in the same cycle as drop_clr keeps the flag set.
  always_comb begin
    drop_d = drop_q;
    if (drop_clr) drop_d = 1'b0;
    if (capture && !wr_ok) drop_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= drop_d;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_data ({ovf_in, ferr_in, perr_in, data_in}),
    .rd_en   (rd),
    .rd_data (head),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  // Head flags are masked while empty so stale memory never shows in status.
  always_comb begin
    rd_status           = 8'h00;
    rd_status[ST_RDY]   = ~empty;
    rd_status[ST_PERR]  = ~empty & head[8];
    rd_status[ST_FERR]  = ~empty & head[9];
    rd_status[ST_OVF]   = ~empty & head[10];
    rd_status[ST_DROP]  = drop_q;
    rd_status[ST_FULL]  = full;
  end

  assign rd_data = head[7:0];
  assign clr_out = clr_q;

endmodule
